// File: rtl/gtx_rx_link_monitor.sv
// gtx_rx_link_monitor: GTX RX reset/retry sequencer and link-up error supervisor
module gtx_rx_link_monitor #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int ERR_WINDOW    = 1024,
  parameter int ERR_THRESHOLD = 8
) (
  input  logic        ref_clk,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic        rx_resetdone,
  input  logic        byteisaligned,
  input  logic        rx_char_err,
  output logic        gtx_rxreset,
  output logic        link_up,
  output logic [1:0]  state,
  output logic [7:0]  retry_count,
  output logic [15:0] err_count
);
  localparam int WW = $clog2(ERR_WINDOW);
  typedef enum logic [1:0] {S_RESET, S_WAIT_DONE, S_WAIT_ALIGN, S_LINKED} state_t;
  state_t state_q, state_d;
  logic [15:0] timer_q, timer_d, err_q, err_d;
  logic [WW-1:0] win_q, win_d;
  logic [7:0] werr_q, werr_d, werr_n, retry_q, retry_d;
  logic wrap, timeout;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 16'd1;
    win_d   = win_q;
    werr_d  = werr_q;
    wrap    = win_q == WW'(ERR_WINDOW - 1);
    timeout = timer_q == 16'(LOCK_TIMEOUT - 1);
    // an error landing in the wrap cycle opens the new window's count
    werr_n  = (wrap ? 8'd0 : werr_q) + 8'(rx_char_err);
    case (state_q)
      S_RESET:      state_d = timer_q == 16'(RESET_CYCLES - 1) ? S_WAIT_DONE : S_RESET;
      S_WAIT_DONE:  state_d = (pll_locked && rx_resetdone) ? S_WAIT_ALIGN : timeout ? S_RESET : S_WAIT_DONE;
      S_WAIT_ALIGN: state_d = byteisaligned ? S_LINKED : timeout ? S_RESET : S_WAIT_ALIGN;
      S_LINKED: begin
        win_d   = wrap ? '0 : win_q + WW'(1);
        werr_d  = werr_n;
        state_d = (!byteisaligned || (rx_char_err && werr_n == 8'(ERR_THRESHOLD))) ? S_RESET : S_LINKED;
      end
    endcase
    if (state_d != state_q) begin
      timer_d = '0;
      win_d   = '0;
      werr_d  = '0;
    end
    retry_d = (state_d == S_RESET && state_q != S_RESET && retry_q != 8'hff) ? retry_q + 8'd1 : retry_q;
    err_d   = (state_q == S_LINKED && rx_char_err && err_q != 16'hffff) ? err_q + 16'd1 : err_q;
  end
  always_ff @(posedge ref_clk or posedge reset)
    if (reset) begin
      state_q <= S_RESET;
      timer_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      retry_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  assign state       = state_q;
  assign gtx_rxreset = state_q == S_RESET;
  assign link_up     = state_q == S_LINKED;
  assign retry_count = retry_q;
  assign err_count   = err_q;
endmodule

// File: tb/tb_gtx_rx_link_monitor.sv
// tb_gtx_rx_link_monitor: directed stimulus checked against a cycle-age model plus literal pins
module tb_gtx_rx_link_monitor;
  localparam int RC = 4, LT = 100, W = 16, TH = 3;
  logic ref_clk = 0, reset = 1;
  logic pll_locked = 0, rx_resetdone = 0, byteisaligned = 0, rx_char_err = 0;
  logic gtx_rxreset, link_up;
  logic [1:0] state;
  logic [7:0] retry_count;
  logic [15:0] err_count;
  int checks = 0, errors = 0, tcyc = 0;
  int cyc, m_state, m_entry, m_retry, m_err, m_wid, m_wcnt;

  gtx_rx_link_monitor #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .ERR_WINDOW(W), .ERR_THRESHOLD(TH)) dut (
    .ref_clk(ref_clk), .reset(reset), .pll_locked(pll_locked), .rx_resetdone(rx_resetdone),
    .byteisaligned(byteisaligned), .rx_char_err(rx_char_err), .gtx_rxreset(gtx_rxreset),
    .link_up(link_up), .state(state), .retry_count(retry_count), .err_count(err_count));

  always #5 ref_clk = ~ref_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, tcyc, got, exp);
    end
  endtask

  // Model: timing from cycle age since state entry; error windows indexed by (age+1)/W
  always @(posedge ref_clk or posedge reset) begin : model
    int age, nxt, wid, wc;
    if (reset) begin
      cyc <= 0; m_state <= 0; m_entry <= 0; m_retry <= 0; m_err <= 0; m_wid <= 0; m_wcnt <= 0;
    end else begin
      age = cyc - m_entry;
      nxt = m_state;
      wid = m_wid;
      wc  = m_wcnt;
      if (m_state == 0) nxt = (age == RC - 1) ? 1 : 0;
      else if (m_state == 1) nxt = (pll_locked && rx_resetdone) ? 2 : (age == LT - 1 ? 0 : 1);
      else if (m_state == 2) nxt = byteisaligned ? 3 : (age == LT - 1 ? 0 : 2);
      else begin
        wid = (age + 1) / W;
        if (wid != m_wid) wc = 0;
        if (rx_char_err) begin
          wc++;
          if (m_err < 65535) m_err <= m_err + 1;
        end
        if (!byteisaligned || (rx_char_err && wc == TH)) nxt = 0;
      end
      if (nxt != m_state) begin
        m_entry <= cyc + 1;
        wid = 0;
        wc  = 0;
        if (nxt == 0 && m_retry < 255) m_retry <= m_retry + 1;
      end
      m_state <= nxt;
      m_wid   <= wid;
      m_wcnt  <= wc;
      cyc     <= cyc + 1;
    end
  end

  always @(posedge ref_clk) begin
    #1;
    chk("state", state, m_state);
    chk("gtx_rxreset", gtx_rxreset, m_state == 0);
    chk("link_up", link_up, m_state == 3);
    chk("retry_count", retry_count, m_retry);
    chk("err_count", err_count, m_err);
  end

  task automatic tick();
    @(negedge ref_clk);
    tcyc++;
  endtask

  task automatic run_to(input int c);
    while (tcyc < c) tick();
  endtask

  initial begin
    repeat (3) @(negedge ref_clk);
    chk("rst_state", state, 0);
    chk("rst_rxreset", gtx_rxreset, 1);
    chk("rst_link", link_up, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_err", err_count, 0);
    pll_locked = 1; rx_resetdone = 1; reset = 0; tcyc = 0;
    for (int i = 0; i < RC; i++) begin
      chk("t1_rxreset_hold", gtx_rxreset, 1);
      tick();
    end
    chk("t1_wait_done", state, 1);
    chk("t1_rxreset_low", gtx_rxreset, 0);
    tick();
    chk("t1_wait_align", state, 2);
    run_to(10);
    byteisaligned = 1;
    tick();
    chk("t1_linked", state, 3);
    chk("t1_link_up", link_up, 1);
    chk("t1_retry", retry_count, 0);
    while (tcyc < 52) begin
      rx_char_err = (tcyc == 12 || tcyc == 16 || tcyc == 26 || tcyc == 31 ||
                     tcyc == 42 || tcyc == 46 || tcyc == 51);
      if (tcyc == 51) chk("t3_two_per_window_up", link_up, 1);
      tick();
    end
    rx_char_err = 0;
    chk("t3_drop_state", state, 0);
    chk("t3_retry", retry_count, 1);
    chk("t3_err", err_count, 7);
    run_to(60);
    chk("t4_relinked", state, 3);
    byteisaligned = 0; rx_char_err = 1;
    tick();
    rx_char_err = 0;
    chk("t4_state", state, 0);
    chk("t4_retry", retry_count, 2);
    chk("t4_err", err_count, 8);
    run_to(165);
    chk("t5_wait_align_edge", state, 2);
    byteisaligned = 1;
    tick();
    chk("t5_linked", state, 3);
    chk("t5_no_retry", retry_count, 2);
    run_to(167);
    rx_char_err = 1;
    tick();
    rx_char_err = 0;
    run_to(170);
    chk("t6_err_pre", err_count, 9);
    reset = 1;
    #1;
    chk("t6_link", link_up, 0);
    chk("t6_rxreset", gtx_rxreset, 1);
    chk("t6_state", state, 0);
    chk("t6_retry", retry_count, 0);
    chk("t6_err", err_count, 0);
    repeat (2) @(negedge ref_clk);
    rx_resetdone = 0; byteisaligned = 0; reset = 0; tcyc = 0;
    run_to(4);
    chk("t2_wait_done", state, 1);
    run_to(103);
    chk("t2_wait_done_last", state, 1);
    tick();
    chk("t2_timeout", state, 0);
    chk("t2_retry1", retry_count, 1);
    run_to(108);
    chk("t2_back_wait", state, 1);
    run_to(104 * 254);
    chk("t2_retry254", retry_count, 254);
    run_to(104 * 300);
    chk("t2_state_end", state, 0);
    chk("t2_retry_sat", retry_count, 255);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
